load_store_unit: RTL

//   Adapts the core's load/store requests to port A of the 32-bit dual-port data BRAM.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store adapter between the memory pipeline stage and port A of the data BRAM.
// One request in flight; produces byte enables and replicated store data, and extends load data.
module load_store_unit #(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int unsigned MEM_SIZE_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_addra,
  output logic [31:0] mem_dina,
  input  logic [31:0] mem_douta
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_LWAIT  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  mem_wea_q, mem_wea_d;
  logic [31:0] mem_addra_q, mem_addra_d;
  logic [31:0] mem_dina_q, mem_dina_d;

  logic        accept;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [31:0] req_offset;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Request classification, valid only while the request is being accepted.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    funct3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !req_we;
      default:                funct3_ok = 1'b0;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_offset   = req_addr - MEM_BASE;
    out_of_range = req_offset >= MEM_SIZE_BYTES;
    req_bad      = !funct3_ok || misaligned || out_of_range;
  end

  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << req_addr[1:0];
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
  end

  // Lane select on the read word; lanes are little-endian within the word.
  always_comb begin
    byte_lane = mem_douta[{addr_lo_q, 3'b000} +: 8];
    half_lane = mem_douta[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = mem_douta;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_wea_d   = 4'b0000;
    mem_addra_d = mem_addra_q;
    mem_dina_d  = mem_dina_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          if (req_bad) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            mem_addra_d = {req_addr[31:2], 2'b00};
            if (req_we) begin
              mem_wea_d  = req_be;
              mem_dina_d = req_wdata_rep;
            end
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = S_LWAIT;
        end
      end
      S_LWAIT: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_wea_q   <= 4'b0000;
      mem_addra_q <= 32'h0;
      mem_dina_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_wea_q   <= mem_wea_d;
      mem_addra_q <= mem_addra_d;
      mem_dina_q  <= mem_dina_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_wea   = mem_wea_q;
  assign mem_addra = mem_addra_q;
  assign mem_dina  = mem_dina_q;

endmodule
